echo_subtractor: RTL

//  Consumer side of the lag generator: removes the estimated echo from the mixed
//  (near-end + echo) sample using the shared 64-bit IEEE-754 double fpu.

---
 rtl/echo_subtractor.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/echo_subtractor.sv
// Echo subtractor: residual = signal_mixed - signal_lag, then residual_sq =
// residual * residual, both in IEEE-754 double, on a single shared fpu
// sequenced by a small FSM. Results are published as a pair in DONE.

// Sequential double-precision unit: add (000), sub (001), mul (010).
// Operands are latched on enable; the result appears LATENCY cycles later with
// ready, which then stays high until the next enable. Inputs with a zero
// exponent are treated as zero; rmode 2'b00 is round-to-nearest-even, any
// other mode truncates.
module echo_fpu #(
    parameter int LATENCY = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [2:0]  fpu_op,
    input  logic [1:0]  rmode,
    input  logic [63:0] opa,
    input  logic [63:0] opb,
    output logic [63:0] out,
    output logic        ready
);
    logic [63:0] opa_reg, opb_reg, out_reg;
    logic [2:0]  op_reg;
    logic [1:0]  rmode_reg;
    logic [7:0]  cnt_reg;
    logic        ready_reg;

    // Round a 56-bit mantissa (hidden, 52 frac, guard, round, sticky) and pack.
    function automatic logic [63:0] round_pack(input logic s, input logic signed [13:0] e,
                                               input logic [55:0] m, input logic rne);
        logic              up;
        logic [53:0]       r;
        logic signed [13:0] e2;
        logic [51:0]       frac;
        up   = rne & m[2] & (m[1] | m[0] | m[3]);
        r    = {1'b0, m[55:3]} + 54'(up);
        frac = r[53] ? r[52:1] : r[51:0];
        e2   = e + 14'(r[53]);
        if (e2 >= 14'sd2047)
            round_pack = {s, 11'h7FF, 52'd0};
        else if (e2 <= 14'sd0)
            round_pack = {s, 63'd0};
        else
            round_pack = {s, e2[10:0], frac};
    endfunction

    logic               sa, sb, za, zb, a_big, hi_s, lo_s, lo_sticky, rne;
    logic [10:0]        ea, eb, e_hi, e_lo, d;
    logic [55:0]        m_hi, m_lo, lo_sh, add_m;
    logic [56:0]        sum;
    logic [5:0]         lz;
    logic signed [13:0] add_e, mul_e;
    logic [105:0]       prod, mul_n;
    logic [55:0]        mul_m;
    logic [63:0]        result;

    // Combinational arithmetic on the latched operands.
    always_comb begin
        sa    = opa_reg[63];
        sb    = opb_reg[63] ^ (op_reg == 3'b001);
        ea    = opa_reg[62:52];
        eb    = opb_reg[62:52];
        za    = (ea == 11'd0);
        zb    = (eb == 11'd0);
        rne   = (rmode_reg == 2'b00);
        a_big = opa_reg[62:0] >= opb_reg[62:0];
        hi_s  = a_big ? sa : sb;
        lo_s  = a_big ? sb : sa;
        e_hi  = a_big ? ea : eb;
        e_lo  = a_big ? eb : ea;
        m_hi  = a_big ? {1'b1, opa_reg[51:0], 3'b000} : {1'b1, opb_reg[51:0], 3'b000};
        m_lo  = a_big ? {1'b1, opb_reg[51:0], 3'b000} : {1'b1, opa_reg[51:0], 3'b000};
        d     = e_hi - e_lo;
        if (d > 11'd55) begin
            lo_sh     = '0;
            lo_sticky = 1'b1;
        end else begin
            lo_sh     = m_lo >> d;
            lo_sticky = |(m_lo & ~({56{1'b1}} << d));
        end
        lo_sh[0] = lo_sh[0] | lo_sticky;
        if (hi_s == lo_s)
            sum = {1'b0, m_hi} + {1'b0, lo_sh};
        else
            sum = {1'b0, m_hi} - {1'b0, lo_sh};
        lz = 6'd0;
        for (int i = 0; i < 56; i++)
            if (sum[i]) lz = 6'(55 - i);
        if (sum[56]) begin
            add_m = {sum[56:2], sum[1] | sum[0]};
            add_e = 14'(e_hi) + 14'sd1;
        end else begin
            add_m = sum[55:0] << lz;
            add_e = 14'(e_hi) - 14'(lz);
        end

        prod  = {1'b1, opa_reg[51:0]} * {1'b1, opb_reg[51:0]};
        mul_n = prod[105] ? prod : {prod[104:0], 1'b0};
        mul_m = {mul_n[105:53], mul_n[52], mul_n[51], |mul_n[50:0]};
        mul_e = 14'(ea) + 14'(eb) - 14'sd1023 + 14'(prod[105]);

        if (op_reg == 3'b010) begin
            if (za || zb) result = {sa ^ sb, 63'd0};
            else          result = round_pack(sa ^ sb, mul_e, mul_m, rne);
        end else begin
            if (za && zb)         result = {sa & sb, 63'd0};
            else if (za)          result = {sb, opb_reg[62:0]};
            else if (zb)          result = opa_reg;
            else if (sum == '0)   result = 64'd0;
            else                  result = round_pack(hi_s, add_e, add_m, rne);
        end
    end

    // Operand latch and latency countdown; ready is a level held until re-enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_reg   <= '0;
            opb_reg   <= '0;
            op_reg    <= '0;
            rmode_reg <= '0;
            cnt_reg   <= '0;
            out_reg   <= '0;
            ready_reg <= 1'b0;
        end else if (enable) begin
            opa_reg   <= opa;
            opb_reg   <= opb;
            op_reg    <= fpu_op;
            rmode_reg <= rmode;
            cnt_reg   <= 8'(LATENCY);
            ready_reg <= 1'b0;
        end else if (cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
            if (cnt_reg == 8'd1) begin
                out_reg   <= result;
                ready_reg <= 1'b1;
            end
        end
    end

    assign out   = out_reg;
    assign ready = ready_reg;
endmodule

module echo_subtractor #(
    parameter int TIMEOUT     = 255,
    parameter int FPU_GUARD   = 2,
    parameter int FPU_LATENCY = 20,
    parameter bit STALL_FPU   = 1'b0   // holds fpu ready low (timeout exercise)
) (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic        lag_ready,
    input  logic [63:0] signal_lag,
    input  logic [63:0] signal_mixed,
    output logic [63:0] residual,
    output logic [63:0] residual_sq,
    output logic        ready,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  drop_count
);
    typedef enum logic [2:0] {IDLE, SUB_ISSUE, SUB_WAIT, MUL_ISSUE, MUL_WAIT, DONE} state_t;

    state_t      state_reg, state_next;
    logic        lag_ready_d_reg, start;
    logic [63:0] lag_reg, mixed_reg, res_int_reg, res_sq_int_reg;
    logic [63:0] residual_reg, residual_sq_reg;
    logic        ready_reg, timeout_reg;
    logic [7:0]  drop_reg, wait_cnt_reg;
    logic        fpu_en, fpu_ready_raw, fpu_ready, wait_accept, wait_expired;
    logic [2:0]  fpu_op;
    logic [1:0]  fpu_rmode;
    logic [63:0] fpu_opa, fpu_opb, fpu_out;

    assign start        = lag_ready & ~lag_ready_d_reg;
    assign fpu_ready    = fpu_ready_raw & ~STALL_FPU;
    // A ready seen inside the guard window may be left over from the previous op.
    assign wait_accept  = (wait_cnt_reg >= 8'(FPU_GUARD)) && fpu_ready;
    assign wait_expired = !wait_accept && (wait_cnt_reg == 8'(TIMEOUT));

    echo_fpu #(.LATENCY(FPU_LATENCY)) u_fpu (
        .clk    (clk_operation),
        .rst    (rst),
        .enable (fpu_en),
        .fpu_op (fpu_op),
        .rmode  (fpu_rmode),
        .opa    (fpu_opa),
        .opb    (fpu_opb),
        .out    (fpu_out),
        .ready  (fpu_ready_raw)
    );

    // FSM state register.
    always_ff @(posedge clk_operation) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state and fpu command decode; enable is a single-cycle pulse per issue state.
    always_comb begin
        state_next = state_reg;
        fpu_en     = 1'b0;
        fpu_op     = 3'b001;
        fpu_rmode  = 2'b00;
        fpu_opa    = mixed_reg;
        fpu_opb    = lag_reg;
        case (state_reg)
            IDLE:      if (start) state_next = SUB_ISSUE;
            SUB_ISSUE: begin
                fpu_en     = 1'b1;
                state_next = SUB_WAIT;
            end
            SUB_WAIT: begin
                if (wait_accept)       state_next = MUL_ISSUE;
                else if (wait_expired) state_next = IDLE;
            end
            MUL_ISSUE: begin
                fpu_en     = 1'b1;
                fpu_op     = 3'b010;
                fpu_opa    = res_int_reg;
                fpu_opb    = res_int_reg;
                state_next = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (wait_accept)       state_next = DONE;
                else if (wait_expired) state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) fpu_en = 1'b0;
    end

    // Datapath: edge detect, capture, shadow results, pair publish, error/drop tracking.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            lag_ready_d_reg <= 1'b0;
            lag_reg         <= '0;
            mixed_reg       <= '0;
            res_int_reg     <= '0;
            res_sq_int_reg  <= '0;
            residual_reg    <= '0;
            residual_sq_reg <= '0;
            ready_reg       <= 1'b0;
            timeout_reg     <= 1'b0;
            drop_reg        <= '0;
            wait_cnt_reg    <= '0;
        end else begin
            lag_ready_d_reg <= lag_ready;
            if (start && state_reg == IDLE) begin
                lag_reg   <= signal_lag;
                mixed_reg <= signal_mixed;
                ready_reg <= 1'b0;
            end
            if (start && state_reg != IDLE && drop_reg != 8'hFF)
                drop_reg <= drop_reg + 8'd1;
            if (state_reg == SUB_ISSUE || state_reg == MUL_ISSUE)
                wait_cnt_reg <= '0;
            else if (state_reg == SUB_WAIT || state_reg == MUL_WAIT)
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            if (state_reg == SUB_WAIT && wait_accept) res_int_reg    <= fpu_out;
            if (state_reg == MUL_WAIT && wait_accept) res_sq_int_reg <= fpu_out;
            if ((state_reg == SUB_WAIT || state_reg == MUL_WAIT) && wait_expired)
                timeout_reg <= 1'b1;
            if (state_reg == DONE) begin
                residual_reg    <= res_int_reg;
                residual_sq_reg <= res_sq_int_reg;
                ready_reg       <= 1'b1;
            end
        end
    end

    assign residual    = residual_reg;
    assign residual_sq = residual_sq_reg;
    assign ready       = ready_reg;
    assign busy        = (state_reg != IDLE);
    assign timeout_err = timeout_reg;
    assign drop_count  = drop_reg;
endmodule
